// File: rtl/booth_seq_multiplier_if.sv
// Streaming handshake bundle for the sequential Booth multiplier:
// an operand channel in and a product channel out, each with valid/ready.
interface booth_seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-2 Booth multiplier: one add/sub-and-shift step per clock,
// run-time signed/unsigned mode, valid/ready handshakes on both sides.
module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    booth_seq_multiplier_if.slave  bus
);
    localparam int W1 = WIDTH + 1;
    localparam int CW = $clog2(W1 + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [W1-1:0]        m_q, m_d;
    logic [W1-1:0]        acc_q, acc_d;
    logic [W1-1:0]        q_q, q_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [W1-1:0]        sum;
    logic                 last_step;

    assign last_step   = (cnt_q == CW'(W1 - 1));
    assign bus.product = product_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = BUSY;
            BUSY:    if (last_step)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // The extra operand bit makes zero-extended unsigned values and -2^(WIDTH-1) exact.
    always_comb begin
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        sum       = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d   = bus.signed_mode ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
                    q_d   = bus.signed_mode ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};
                    acc_d = '0;
                    q1_d  = 1'b0;
                    cnt_d = '0;
                end
            end
            BUSY: begin
                case ({q_q[0], q1_q})
                    2'b01:   sum = acc_q + m_q;
                    2'b10:   sum = acc_q - m_q;
                    default: sum = acc_q;
                endcase
                acc_d = {sum[W1-1], sum[W1-1:1]};
                q_d   = {sum[0], q_q[W1-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    product_d = {acc_d[WIDTH-2:0], q_d};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier at WIDTH=8 and WIDTH=16:
// expected products are queued on acceptance and compared when the DUT delivers.
module tb_booth_seq_multiplier;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;

    logic [15:0] sb8[$];
    logic [31:0] sb16[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    booth_seq_multiplier_if #(.WIDTH(8))  bus8();
    booth_seq_multiplier_if #(.WIDTH(16)) bus16();

    booth_seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    booth_seq_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        logic signed [15:0] sp;
        logic [15:0]        up;
        sp = $signed(a) * $signed(b);
        up = {8'd0, a} * {8'd0, b};
        return sm ? sp : up;
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic sm);
        logic signed [31:0] sp;
        logic [31:0]        up;
        sp = $signed(a) * $signed(b);
        up = {16'd0, a} * {16'd0, b};
        return sm ? sp : up;
    endfunction

    // Offer one operand pair; returns #1 after the accepting edge with the expectation queued.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm, output bit ok);
        ok = 1'b0;
        bus8.a = a; bus8.b = b; bus8.signed_mode = sm; bus8.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus8.in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk);
            sb8.push_back(model8(a, b, sm));
            #1;
        end
        bus8.in_valid = 1'b0;
    endtask

    task automatic collect8(input int stall, output logic [15:0] prod, output int lat, output bit ok);
        ok = 1'b0; lat = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus8.out_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1; lat++;
        end
        prod = bus8.product;
        if (ok) begin
            repeat (stall) begin @(posedge clk); #1; end
            bus8.out_ready = 1'b1;
            @(posedge clk); #1;
            bus8.out_ready = 1'b0;
        end
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sm, output bit ok);
        ok = 1'b0;
        bus16.a = a; bus16.b = b; bus16.signed_mode = sm; bus16.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus16.in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk);
            sb16.push_back(model16(a, b, sm));
            #1;
        end
        bus16.in_valid = 1'b0;
    endtask

    task automatic collect16(input int stall, output logic [31:0] prod, output int lat, output bit ok);
        ok = 1'b0; lat = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus16.out_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1; lat++;
        end
        prod = bus16.product;
        if (ok) begin
            repeat (stall) begin @(posedge clk); #1; end
            bus16.out_ready = 1'b1;
            @(posedge clk); #1;
            bus16.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus8.in_ready); end
        n_checks++;
        if (bus8.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus8.out_valid); end
        n_checks++;
        if (bus8.product !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_product: got %h, expected 0000", bus8.product); end
        n_checks++;
        if (bus16.product !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_product16: got %h, expected 0", bus16.product); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed(input string name, input logic [7:0] a, input logic [7:0] b,
                                 input logic sm, input logic [15:0] want);
        bit          ok;
        int          lat;
        logic [15:0] prod;
        logic [15:0] exp;
        issue8(a, b, sm, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL %s_accept: got timeout, expected acceptance", name); return; end
        collect8(0, prod, lat, ok);
        exp = sb8.pop_front();
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL %s_out_valid: got timeout, expected out_valid", name); return; end
        n_checks++;
        if (lat != 9) begin n_fail++; $display("[TB] FAIL %s_latency: got %0d, expected 9", name, lat); end
        n_checks++;
        if (prod !== want) begin n_fail++; $display("[TB] FAIL %s_product: got %h, expected %h", name, prod, want); end
        n_checks++;
        if (prod !== exp) begin n_fail++; $display("[TB] FAIL %s_scoreboard: got %h, expected %h", name, prod, exp); end
    endtask

    task automatic test_backpressure();
        bit          ok;
        logic [15:0] held;
        logic [15:0] exp;
        issue8(8'd25, 8'd9, 1'b0, ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus8.out_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL bp_out_valid: got timeout, expected out_valid"); return; end
        held = bus8.product;
        exp  = sb8.pop_front();
        n_checks++;
        if (held !== exp) begin n_fail++; $display("[TB] FAIL bp_product: got %h, expected %h", held, exp); end
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = 1'($urandom_range(0, 1));
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (bus8.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_valid: got %b, expected 1", bus8.out_valid); end
            n_checks++;
            if (bus8.product !== exp) begin n_fail++; $display("[TB] FAIL bp_hold_product: got %h, expected %h", bus8.product, exp); end
            n_checks++;
            if (bus8.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready: got %b, expected 0", bus8.in_ready); end
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        n_checks++;
        if (bus8.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_overlap: got %b, expected 0", bus8.in_ready); end
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        n_checks++;
        if (bus8.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drop_valid: got %b, expected 0", bus8.out_valid); end
        n_checks++;
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_back: got %b, expected 1", bus8.in_ready); end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int seen;
        issue8(8'd50, 8'd3, 1'b1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL rmo_accept: got timeout, expected acceptance"); return; end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb8.delete();
        n_checks++;
        if (bus8.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmo_in_ready: got %b, expected 1", bus8.in_ready); end
        n_checks++;
        if (bus8.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rmo_out_valid: got %b, expected 0", bus8.out_valid); end
        n_checks++;
        if (bus8.product !== 16'h0000) begin n_fail++; $display("[TB] FAIL rmo_product: got %h, expected 0000", bus8.product); end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus8.out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("[TB] FAIL rmo_no_output: got %0d valid cycles, expected 0", seen); end
        test_directed("after_reset", 8'd100, 8'hCE, 1'b1, 16'hEC78);
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          lat;
        int          accepted[3];
        logic [15:0] prod;
        logic [15:0] exp;
        for (int i = 0; i < 3; i++) begin
            issue8(8'(i * 37 + 5), 8'(200 - i * 11), 1'(i % 2), ok);
            accepted[i] = cycle;
            n_checks++;
            if (!ok) begin n_fail++; $display("[TB] FAIL b2b_accept: got timeout, expected acceptance"); return; end
            collect8(0, prod, lat, ok);
            exp = sb8.pop_front();
            n_checks++;
            if (!ok || prod !== exp) begin n_fail++; $display("[TB] FAIL b2b_product: got %h, expected %h", prod, exp); end
            if (i > 0) begin
                n_checks++;
                if (accepted[i] - accepted[i-1] != 11) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_spacing: got %0d, expected 11", accepted[i] - accepted[i-1]);
                end
            end
        end
    endtask

    task automatic test_random8(input int n);
        bit          ok;
        int          lat;
        logic [15:0] prod;
        logic [15:0] exp;
        for (int i = 0; i < n; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("[TB] FAIL rnd8_accept: got timeout, expected acceptance"); return; end
            collect8($urandom_range(0, 3), prod, lat, ok);
            exp = sb8.pop_front();
            n_checks++;
            if (!ok || lat != 9) begin n_fail++; $display("[TB] FAIL rnd8_latency: got %0d, expected 9", lat); end
            n_checks++;
            if (prod !== exp) begin n_fail++; $display("[TB] FAIL rnd8_product: got %h, expected %h", prod, exp); end
        end
    endtask

    task automatic test_random16(input int n);
        bit          ok;
        int          lat;
        logic [31:0] prod;
        logic [31:0] exp;
        for (int i = 0; i < n; i++) begin
            issue16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("[TB] FAIL rnd16_accept: got timeout, expected acceptance"); return; end
            collect16($urandom_range(0, 3), prod, lat, ok);
            exp = sb16.pop_front();
            n_checks++;
            if (!ok || lat != 17) begin n_fail++; $display("[TB] FAIL rnd16_latency: got %0d, expected 17", lat); end
            n_checks++;
            if (prod !== exp) begin n_fail++; $display("[TB] FAIL rnd16_product: got %h, expected %h", prod, exp); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.signed_mode  = 1'b0; bus8.out_ready  = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.signed_mode = 1'b0; bus16.out_ready = 1'b0;
        test_reset();
        test_directed("signed_7x-3", 8'd7, 8'hFD, 1'b1, 16'hFFEB);
        test_directed("signed_min", 8'h80, 8'h80, 1'b1, 16'h4000);
        test_directed("unsigned_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        test_directed("signed_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random8(2000);
        test_random16(500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
